// File: rtl/ssd1331_spi_txn_arbiter_pkg.sv
// Shared definitions for the SSD1331 SPI transaction arbiter: FSM states,
// default CS timing and a counter-width helper.
package ssd1331_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int unsigned CS_SETUP_DEF = 2;
    localparam int unsigned CS_HOLD_DEF  = 2;
    localparam int unsigned CS_GAP_DEF   = 3;
    localparam int unsigned TIMEOUT_DEF  = 1024;

    // Bits needed to count 0..v-1, never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ssd1331_spi_txn_arbiter_if.sv
// Requester and buffer-side signal bundle of the SSD1331 SPI transaction arbiter.
interface ssd1331_spi_txn_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned R     = 2,
    parameter int unsigned LENW  = 4
);
    logic [R-1:0]         i_REQ;
    logic [R*WIDTH*N-1:0] i_DATA;
    logic [R*N-1:0]       i_DC;
    logic [R*LENW-1:0]    i_LEN;
    logic                 i_BUF_FINAL;
    logic [WIDTH*N-1:0]   o_BUF_DATA;
    logic [N-1:0]         o_BUF_DC;
    logic [LENW-1:0]      o_BUF_LEN;
    logic                 o_BUF_START;
    logic                 o_CS_N;
    logic [R-1:0]         o_GNT;
    logic [R-1:0]         o_DONE;
    logic                 o_ERR;
    logic                 o_BUSY;

    modport master (
        input  i_REQ, i_DATA, i_DC, i_LEN, i_BUF_FINAL,
        output o_BUF_DATA, o_BUF_DC, o_BUF_LEN, o_BUF_START, o_CS_N,
               o_GNT, o_DONE, o_ERR, o_BUSY
    );

    modport slave (
        output i_REQ, i_DATA, i_DC, i_LEN, i_BUF_FINAL,
        input  o_BUF_DATA, o_BUF_DC, o_BUF_LEN, o_BUF_START, o_CS_N,
               o_GNT, o_DONE, o_ERR, o_BUSY
    );
endinterface

// File: rtl/ssd1331_spi_txn_arbiter_rr_arbiter_onehot.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter_onehot
    import ssd1331_pkg::*;
#(
    parameter int unsigned R  = 2,
    parameter int unsigned PW = clog2_min1(R)
) (
    input  logic [R-1:0]  i_REQ,
    input  logic [PW-1:0] i_PTR,
    output logic [R-1:0]  o_GNT
);
    logic [PW-1:0] k;
    logic          found;

    always_comb begin
        o_GNT = '0;
        k     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < R; i++) begin
            k = PW'((32'(i_PTR) + i) % R);
            if (!found && i_REQ[k]) begin
                o_GNT[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ssd1331_spi_txn_arbiter.sv
// Shares one MOSI SPI buffer between R requesters: round-robin grant, CS_N
// setup/hold/gap sequencing, launch pulse, final-byte wait with timeout.
module ssd1331_spi_txn_arbiter
    import ssd1331_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N        = 8,
    parameter int unsigned R        = 2,
    parameter int unsigned LENW     = 4,
    parameter int unsigned CS_SETUP = CS_SETUP_DEF,
    parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
    parameter int unsigned CS_GAP   = CS_GAP_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                       i_SCK,
    input  logic                       i_RST_N,
    ssd1331_spi_txn_arbiter_if.master  bus
);
    localparam int unsigned PW = clog2_min1(R);
    localparam int unsigned M1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned M2 = (M1 > CS_GAP) ? M1 : CS_GAP;
    localparam int unsigned CW = clog2_min1((M2 > TIMEOUT) ? M2 : TIMEOUT);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    // The START cycle counts as the first cycle of the timeout window.
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 2);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      ptr;
    logic [R-1:0]       arb_gnt;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      ptr_nxt;
    logic [WIDTH*N-1:0] sel_data;
    logic [N-1:0]       sel_dc;
    logic [LENW-1:0]    sel_len;

    rr_arbiter_onehot #(.R(R), .PW(PW)) u_rr (
        .i_REQ (bus.i_REQ),
        .i_PTR (ptr),
        .o_GNT (arb_gnt)
    );

    always_comb begin
        sel_data = '0;
        sel_dc   = '0;
        sel_len  = '0;
        win_idx  = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (arb_gnt[i]) begin
                sel_data = bus.i_DATA[i*WIDTH*N +: WIDTH*N];
                sel_dc   = bus.i_DC[i*N +: N];
                sel_len  = bus.i_LEN[i*LENW +: LENW];
                win_idx  = PW'(i);
            end
        end
        ptr_nxt = (win_idx == PW'(R - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge i_SCK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            ptr             <= '0;
            bus.o_CS_N      <= 1'b1;
            bus.o_GNT       <= '0;
            bus.o_DONE      <= '0;
            bus.o_ERR       <= 1'b0;
            bus.o_BUF_START <= 1'b0;
            bus.o_BUSY      <= 1'b0;
            bus.o_BUF_DATA  <= '0;
            bus.o_BUF_DC    <= '0;
            bus.o_BUF_LEN   <= '0;
        end else begin
            bus.o_BUF_START <= 1'b0;
            bus.o_DONE      <= '0;
            bus.o_ERR       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        bus.o_BUF_DATA <= sel_data;
                        bus.o_BUF_DC   <= sel_dc;
                        bus.o_BUF_LEN  <= sel_len;
                        bus.o_GNT      <= arb_gnt;
                        bus.o_BUSY     <= 1'b1;
                        ptr            <= ptr_nxt;
                        if (sel_len != '0) begin
                            bus.o_CS_N <= 1'b0;
                            state      <= ST_SETUP;
                            cnt        <= '0;
                        end else begin
                            // Empty transfer: reuse HOLD's exit edge with CS already high.
                            state <= ST_HOLD;
                            cnt   <= HOLD_LAST;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state           <= ST_LAUNCH;
                        bus.o_BUF_START <= 1'b1;
                        cnt             <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (bus.i_BUF_FINAL) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        bus.o_ERR <= 1'b1;
                        state     <= ST_HOLD;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        bus.o_CS_N <= 1'b1;
                        bus.o_DONE <= bus.o_GNT;
                        bus.o_GNT  <= '0;
                        state      <= ST_GAP;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state      <= ST_IDLE;
                        bus.o_BUSY <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssd1331_spi_txn_arbiter.sv
// Directed self-checking bench for ssd1331_spi_txn_arbiter (R=2, N=8, WIDTH=8).
module tb_ssd1331_spi_txn_arbiter;

    logic i_SCK = 1'b0;
    logic i_RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;

    ssd1331_spi_txn_arbiter_if #(.WIDTH(8), .N(8), .R(2), .LENW(4)) bus ();

    ssd1331_spi_txn_arbiter #(
        .WIDTH(8), .N(8), .R(2), .LENW(4),
        .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(3), .TIMEOUT(1024)
    ) dut (
        .i_SCK   (i_SCK),
        .i_RST_N (i_RST_N),
        .bus     (bus)
    );

    always #5 i_SCK = ~i_SCK;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge i_SCK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return bus.o_GNT != 2'b00;
            1:       return bus.o_BUF_START === 1'b1;
            2:       return bus.o_DONE != 2'b00;
            default: return bus.o_BUSY === 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int limit);
        int n = 0;
        while (!cond(which) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < limit), 64'd1);
    endtask

    task automatic final_pulse();
        bus.i_BUF_FINAL = 1'b1;
        tick();
        bus.i_BUF_FINAL = 1'b0;
    endtask

    initial begin
        int gap;
        logic [1:0] exp_g;
        bus.i_REQ       = '0;
        bus.i_DATA      = {D1, D0};
        bus.i_DC        = '0;
        bus.i_LEN       = '0;
        bus.i_BUF_FINAL = 1'b0;
        tick(2);

        // Reset values
        chk("rst cs_n",  64'(bus.o_CS_N), 64'd1);
        chk("rst gnt",   64'(bus.o_GNT), 64'd0);
        chk("rst done",  64'(bus.o_DONE), 64'd0);
        chk("rst err",   64'(bus.o_ERR), 64'd0);
        chk("rst start", 64'(bus.o_BUF_START), 64'd0);
        chk("rst busy",  64'(bus.o_BUSY), 64'd0);
        chk("rst data",  bus.o_BUF_DATA, 64'd0);
        chk("rst dc",    64'(bus.o_BUF_DC), 64'd0);
        chk("rst len",   64'(bus.o_BUF_LEN), 64'd0);
        i_RST_N = 1'b1;

        // Single r0 transaction, LEN=3, FINAL 24 cycles after START
        bus.i_LEN = {4'd0, 4'd3};
        bus.i_DC  = {8'h00, 8'h01};
        bus.i_REQ = 2'b01;
        tick();
        chk("t1 gnt",   64'(bus.o_GNT), 64'h1);
        chk("t1 cs lo", 64'(bus.o_CS_N), 64'd0);
        chk("t1 data",  bus.o_BUF_DATA, D0);
        chk("t1 len",   64'(bus.o_BUF_LEN), 64'd3);
        chk("t1 dc",    64'(bus.o_BUF_DC), 64'h01);
        chk("t1 st0",   64'(bus.o_BUF_START), 64'd0);
        bus.i_REQ = 2'b00;
        tick();
        chk("t1 st1",   64'(bus.o_BUF_START), 64'd0);
        tick();
        chk("t1 st2",   64'(bus.o_BUF_START), 64'd1);
        tick();
        chk("t1 st3",   64'(bus.o_BUF_START), 64'd0);
        chk("t1 err",   64'(bus.o_ERR), 64'd0);
        tick(22);
        final_pulse();
        chk("t1 cs f0",   64'(bus.o_CS_N), 64'd0);
        chk("t1 done f0", 64'(bus.o_DONE), 64'd0);
        tick();
        chk("t1 done f1", 64'(bus.o_DONE), 64'd0);
        chk("t1 cs f1",   64'(bus.o_CS_N), 64'd0);
        tick();
        chk("t1 done",    64'(bus.o_DONE), 64'h1);
        chk("t1 cs hi",   64'(bus.o_CS_N), 64'd1);
        chk("t1 gnt clr", 64'(bus.o_GNT), 64'd0);
        chk("t1 data hold", bus.o_BUF_DATA, D0);
        tick();
        chk("t1 done clr", 64'(bus.o_DONE), 64'd0);
        chk("t1 busy g1",  64'(bus.o_BUSY), 64'd1);
        tick();
        chk("t1 busy g2",  64'(bus.o_BUSY), 64'd1);
        tick();
        chk("t1 idle",     64'(bus.o_BUSY), 64'd0);

        // r1 with LEN=0: grant for one cycle, DONE next, no CS, no START
        bus.i_LEN = {4'd0, 4'd3};
        bus.i_REQ = 2'b10;
        tick();
        chk("t3 gnt",  64'(bus.o_GNT), 64'h2);
        chk("t3 cs",   64'(bus.o_CS_N), 64'd1);
        chk("t3 busy", 64'(bus.o_BUSY), 64'd1);
        chk("t3 len",  64'(bus.o_BUF_LEN), 64'd0);
        chk("t3 data", bus.o_BUF_DATA, D1);
        bus.i_REQ = 2'b00;
        tick();
        chk("t3 gnt clr", 64'(bus.o_GNT), 64'd0);
        chk("t3 done",    64'(bus.o_DONE), 64'h2);
        chk("t3 start",   64'(bus.o_BUF_START), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3 cs gap", 64'(bus.o_CS_N), 64'd1);
            chk("t3 start gap", 64'(bus.o_BUF_START), 64'd0);
        end
        tick();
        chk("t3 idle", 64'(bus.o_BUSY), 64'd0);

        // Both requesting continuously: r0, r1, r0, r1
        bus.i_LEN = {4'd1, 4'd2};
        bus.i_REQ = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
            wait_sig("t2 wait gnt", 0, 40);
            chk("t2 gnt", 64'(bus.o_GNT), 64'(exp_g));
            chk("t2 data", bus.o_BUF_DATA, (t % 2 == 1) ? D1 : D0);
            if (t == 3) bus.i_REQ = 2'b00;
            wait_sig("t2 wait start", 1, 10);
            tick(3);
            final_pulse();
            wait_sig("t2 wait done", 2, 10);
            chk("t2 done", 64'(bus.o_DONE), 64'(exp_g));
            if (t < 3) begin
                gap = 0;
                while (bus.o_CS_N === 1'b1 && gap < 20) begin
                    gap++;
                    tick();
                end
                chk("t2 cs gap", 64'(gap), 64'd4);
            end
        end
        wait_sig("t2 wait idle", 3, 10);

        // Timeout: no FINAL, ERR exactly 1024 cycles after START
        bus.i_LEN = {4'd1, 4'd3};
        bus.i_REQ = 2'b01;
        wait_sig("t4 wait gnt", 0, 10);
        chk("t4 gnt", 64'(bus.o_GNT), 64'h1);
        bus.i_REQ = 2'b00;
        wait_sig("t4 wait start", 1, 10);
        tick(1023);
        chk("t4 err early", 64'(bus.o_ERR), 64'd0);
        tick();
        chk("t4 err",    64'(bus.o_ERR), 64'd1);
        chk("t4 cs lo",  64'(bus.o_CS_N), 64'd0);
        tick();
        chk("t4 err clr", 64'(bus.o_ERR), 64'd0);
        chk("t4 done0",   64'(bus.o_DONE), 64'd0);
        tick();
        chk("t4 done",   64'(bus.o_DONE), 64'h1);
        chk("t4 cs hi",  64'(bus.o_CS_N), 64'd1);
        wait_sig("t4 wait idle", 3, 10);
        bus.i_REQ = 2'b10;
        wait_sig("t4 next gnt", 0, 10);
        chk("t4 next gnt val", 64'(bus.o_GNT), 64'h2);
        bus.i_REQ = 2'b00;
        wait_sig("t4 next start", 1, 10);
        tick(2);
        final_pulse();
        wait_sig("t4 next done", 2, 10);
        chk("t4 next done val", 64'(bus.o_DONE), 64'h2);
        chk("t4 next err", 64'(bus.o_ERR), 64'd0);
        wait_sig("t4 next idle", 3, 10);

        // Asynchronous reset during WAIT, r1 pending
        bus.i_LEN = {4'd1, 4'd2};
        bus.i_REQ = 2'b01;
        wait_sig("t5 wait gnt", 0, 10);
        chk("t5 gnt", 64'(bus.o_GNT), 64'h1);
        bus.i_REQ = 2'b00;
        wait_sig("t5 wait start", 1, 10);
        tick(3);
        bus.i_REQ = 2'b10;
        #2 i_RST_N = 1'b0;
        #1;
        chk("t5 cs async",   64'(bus.o_CS_N), 64'd1);
        chk("t5 gnt async",  64'(bus.o_GNT), 64'd0);
        chk("t5 busy async", 64'(bus.o_BUSY), 64'd0);
        chk("t5 data async", bus.o_BUF_DATA, 64'd0);
        tick();
        chk("t5 no done", 64'(bus.o_DONE), 64'd0);
        tick();
        i_RST_N = 1'b1;
        tick();
        chk("t5 gnt r1", 64'(bus.o_GNT), 64'h2);
        chk("t5 cs lo",  64'(bus.o_CS_N), 64'd0);
        bus.i_REQ = 2'b00;
        wait_sig("t5 wait start2", 1, 10);
        tick();
        final_pulse();
        wait_sig("t5 wait done", 2, 10);
        chk("t5 done", 64'(bus.o_DONE), 64'h2);
        wait_sig("t5 wait idle", 3, 10);

        // Inputs change after grant: latched bundle must not move
        bus.i_DATA = {D1, D0};
        bus.i_LEN  = {4'd1, 4'd3};
        bus.i_DC   = {8'h00, 8'h05};
        bus.i_REQ  = 2'b01;
        wait_sig("t6 wait gnt", 0, 10);
        chk("t6 data", bus.o_BUF_DATA, D0);
        tick();
        bus.i_DATA = {D1, 64'hFFFF_FFFF_FFFF_FFFF};
        bus.i_LEN  = {4'd1, 4'd7};
        bus.i_DC   = {8'h00, 8'hFF};
        bus.i_REQ  = 2'b00;
        wait_sig("t6 wait start", 1, 10);
        chk("t6 data start", bus.o_BUF_DATA, D0);
        tick(5);
        final_pulse();
        wait_sig("t6 wait done", 2, 10);
        chk("t6 done",      64'(bus.o_DONE), 64'h1);
        chk("t6 data done", bus.o_BUF_DATA, D0);
        chk("t6 len done",  64'(bus.o_BUF_LEN), 64'd3);
        chk("t6 dc done",   64'(bus.o_BUF_DC), 64'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
